// File: rtl/product_accum_tt.sv
// Burst accumulator of signed 8-bit Booth products into a 16-bit sum, read out as two bytes.
// Optional macro PRODUCT_ACCUM_SAT_EN: saturating adds with a sticky ovf flag (default build wraps, ovf=0).
module product_accum_tt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             keep,
  input  logic [CNT_W-1:0] len,
  input  logic             prod_valid,
  input  logic [7:0]       prod_data,
  output logic             prod_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe,
  output logic             busy,
  output logic             ovf
);

  // Handshakes: a product transfers on a rising edge where prod_valid && prod_ready;
  // a result byte transfers on a rising edge where out_valid && out_ready. Both are
  // only live while ena=1, and out_valid/uio_out never change while out_ready=0.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    OUT_LO = 2'd2,
    OUT_HI = 2'd3
  } state_t;

  state_t state, state_nxt;

  // One extra bit so a zero length can load the full 2^CNT_W count.
  logic [CNT_W:0] cnt, cnt_nxt;
  logic [15:0]    acc, acc_nxt;
  logic           ovf_r, ovf_nxt;

  logic [16:0] sum_ext;
  logic        add_ovf;
  logic [15:0] add_res;
  logic        sat_hit;

  assign sum_ext = {acc[15], acc} + {{9{prod_data[7]}}, prod_data};
  assign add_ovf = sum_ext[16] ^ sum_ext[15];

`ifdef PRODUCT_ACCUM_SAT_EN
  // On overflow the clamp direction follows the accumulator sign (operand signs agree).
  assign add_res = add_ovf ? (acc[15] ? 16'h8000 : 16'h7FFF) : sum_ext[15:0];
  assign sat_hit = add_ovf;
`else
  assign add_res = sum_ext[15:0];
  assign sat_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      ovf_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    ovf_nxt   = ovf_r;
    if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = ACC;
            cnt_nxt   = (len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len};
            if (!keep) begin
              acc_nxt = '0;
              ovf_nxt = 1'b0;
            end
          end
        end
        ACC: begin
          if (prod_valid) begin
            acc_nxt = add_res;
            ovf_nxt = ovf_r | sat_hit;
            cnt_nxt = cnt - 1'b1;
            if (cnt == (CNT_W+1)'(1)) state_nxt = OUT_LO;
          end
        end
        OUT_LO: begin
          if (out_ready) state_nxt = OUT_HI;
        end
        OUT_HI: begin
          if (out_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decode registered state/acc only, so they freeze whenever ena=0.
  always_comb begin
    prod_ready = ena && (state == ACC);
    out_valid  = (state == OUT_LO) || (state == OUT_HI);
    busy       = (state != IDLE);
    uio_out    = 8'h00;
    if (state == OUT_LO) uio_out = acc[7:0];
    if (state == OUT_HI) uio_out = acc[15:8];
    uio_oe     = out_valid ? 8'hFF : 8'h00;
  end

  assign ovf = ovf_r;

endmodule

// File: doc/product_accum_tt.md
PRODUCT_ACCUM_TT -- requirements
Module: product_accum_tt

Interface
REQ-001 Parameter CNT_W, default 4: width of burst-length field; burst of 0 means 2^CNT_W products.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 ena  input  1  design enable; low freezes all state.
REQ-005 start  input  1  one-cycle request to begin a burst.
REQ-006 keep  input  1  sampled with start; 1 = retain accumulator, 0 = clear it.
REQ-007 len  input  CNT_W  number of products in burst, sampled with start.
REQ-008 prod_valid  input  1  upstream Booth product valid.
REQ-009 prod_data  input  8  signed two's-complement product from the multiplier stage.
REQ-010 prod_ready  output  1  product accepted when prod_valid and prod_ready are both high on a clock edge.
REQ-011 out_ready  input  1  downstream accepts current result byte.
REQ-012 out_valid  output  1  result byte on uio_out valid.
REQ-013 uio_out  output  8  result byte (low byte first, then high byte).
REQ-014 uio_oe  output  8  8'hFF while out_valid, else 8'h00.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 ovf  output  1  sticky overflow flag.

Function
REQ-017 FSM states SHALL be IDLE, ACC, OUT_LO, OUT_HI; every transition is qualified by ena=1.
REQ-018 IDLE: start=1 -> ACC; capture len into down-counter (0 loads 2^CNT_W); keep=0 clears 16-bit accumulator and ovf.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 ACC: prod_ready=1; each accepted product SHALL be sign-extended to 16 bits and added to accumulator in the same edge; counter decrements.
REQ-021 Acceptance of the last product of the burst SHALL move ACC -> OUT_LO on that edge; prod_ready SHALL be 0 in all other states.
REQ-022 prod_valid=0 in ACC SHALL leave accumulator and counter unchanged (stall, no timeout).
REQ-023 OUT_LO: out_valid=1, uio_out=acc[7:0]; out_ready=1 -> OUT_HI.
REQ-024 OUT_HI: out_valid=1, uio_out=acc[15:8]; out_ready=1 -> IDLE.
REQ-025 uio_out SHALL hold stable while out_valid=1 and out_ready=0; uio_out=8'h00 when out_valid=0.
REQ-026 Latency: first result byte valid the cycle after the last product accept; two-byte readout takes at least 2 cycles.
REQ-027 ena=0 SHALL force prod_ready=0, hold state, accumulator, counter, ovf; out_valid/uio_out keep their registered values.
REQ-028 Product 8'h80 (-128) SHALL be handled as -128, not +128.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, accumulator 0, counter 0, ovf 0, prod_ready 0, out_valid 0, uio_out 8'h00, uio_oe 8'h00, busy 0.
REQ-030 Reset mid-burst or mid-readout SHALL discard the burst; no partial result is emitted after release.
REQ-031 First edge after rst deassertion SHALL be a normal IDLE cycle.

Configuration
REQ-032 Macro PRODUCT_ACCUM_SAT_EN defined: additions saturate to 16'h7FFF / 16'h8000 on signed overflow and set ovf (sticky until keep=0 start or reset).
REQ-033 Macro not defined: additions wrap modulo 2^16; ovf SHALL be tied 0.

Verification
REQ-034 start,len=3,keep=0; products 5,-2,7; out_ready=1 -> bytes 8'h0A then 8'h00, busy drops after OUT_HI.
REQ-035 len=0, sixteen products 8'h80 -> acc 16'hF800; bytes 8'h00, 8'hF8.
REQ-036 len=2, prod_valid gaps of 3 cycles and out_ready held low 4 cycles in OUT_LO -> no extra accepts, uio_out stable, correct sum.
REQ-037 keep=1 bursts from acc 16'h7FF0 adding 127 -> SAT_EN: 16'h7FFF, ovf=1; no SAT_EN: 16'h806F, ovf=0.
REQ-038 rst pulse during ACC after 2 of 4 products, then len=1 burst of 3 -> result 16'h0003, no stale byte output.
REQ-039 ena=0 for 5 cycles in ACC with prod_valid=1 -> prod_ready=0, no accepts; resume correctly when ena=1.
